// File: rtl/fp16_vmul_ctrl.sv
// fp16_vmul_ctrl: initiator-side controller for an fp16 multiply pipeline.
// Joins operand streams A/B into multiplier issues, limits in-flight
// products with a credit counter, and re-registers the products as a result
// stream tagged with res_last.
// Optional build macro FP16_VMUL_ABORT_EN adds i_abort / o_aborted and a
// FLUSH state that discards in-flight products.
module fp16_vmul_ctrl #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [15:0]      i_a_data,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [15:0]      i_b_data,
  output logic             o_mul_in_valid,
  input  logic             i_mul_in_ready,
  output logic [15:0]      o_mul_in_a,
  output logic [15:0]      o_mul_in_b,
  input  logic             i_mul_out_valid,
  output logic             o_mul_out_ready,
  input  logic [15:0]      i_mul_out_prod,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [15:0]      o_res_data,
  output logic             o_res_last,
  output logic             o_busy,
  output logic             o_done
`ifdef FP16_VMUL_ABORT_EN
  , input  logic           i_abort
  , output logic           o_aborted
`endif
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
`ifdef FP16_VMUL_ABORT_EN
    , S_FLUSH = 3'd4
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_collected;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_res_valid;
  logic             r_res_last;
  logic [15:0]      r_res_data;

  logic w_mul_in_valid;
  logic w_mul_out_ready;
  logic w_cmd_fire;
  logic w_issue_fire;
  logic w_collect_fire;
  logic w_res_fire;
  logic w_collect_ok;
  logic w_abort;
  logic w_in_flush;

`ifdef FP16_VMUL_ABORT_EN
  logic r_aborted;
  assign w_abort    = i_abort;
  assign w_in_flush = (r_state == S_FLUSH);
  assign o_aborted  = r_aborted;
`else
  assign w_abort    = 1'b0;
  assign w_in_flush = 1'b0;
`endif

  assign w_cmd_fire     = i_cmd_valid && (r_state == S_IDLE);
  assign w_issue_fire   = w_mul_in_valid && i_mul_in_ready;
  assign w_collect_fire = w_mul_out_ready && i_mul_out_valid;
  assign w_res_fire     = r_res_valid && i_res_ready;
  // A product may only be taken when one is owed and the result slot frees.
  assign w_collect_ok   = (r_outstanding != '0) && (!r_res_valid || i_res_ready);

  assign o_cmd_ready     = (r_state == S_IDLE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE);
  assign o_mul_in_valid  = w_mul_in_valid;
  assign o_mul_out_ready = w_mul_out_ready;
  assign o_a_ready       = w_issue_fire;
  assign o_b_ready       = w_issue_fire;
  assign o_mul_in_a      = i_a_data;
  assign o_mul_in_b      = i_b_data;
  assign o_res_valid     = r_res_valid;
  assign o_res_data      = r_res_data;
  assign o_res_last      = r_res_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_mul_in_valid  = 1'b0;
    w_mul_out_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) w_state_nxt = (i_cmd_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        w_mul_in_valid  = i_a_valid && i_b_valid && (r_issued < r_len) &&
                          (r_outstanding < OUT_W'(MAX_OUT)) && !w_abort;
        w_mul_out_ready = w_collect_ok;
        if (r_issued == r_len) w_state_nxt = S_DRAIN;
`ifdef FP16_VMUL_ABORT_EN
        if (w_abort) w_state_nxt = S_FLUSH;
`endif
      end
      S_DRAIN: begin
        w_mul_out_ready = w_collect_ok;
        if (w_res_fire && r_res_last) w_state_nxt = S_DONE;
`ifdef FP16_VMUL_ABORT_EN
        if (w_abort) w_state_nxt = S_FLUSH;
`endif
      end
`ifdef FP16_VMUL_ABORT_EN
      S_FLUSH: begin
        w_mul_out_ready = (r_outstanding != '0);
        if ((r_outstanding == '0) && !r_res_valid) w_state_nxt = S_DONE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Element counters, credit counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len         <= '0;
      r_issued      <= '0;
      r_collected   <= '0;
      r_outstanding <= '0;
      r_res_valid   <= 1'b0;
      r_res_last    <= 1'b0;
      r_res_data    <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_len         <= CNT_W'(i_cmd_len);
        r_issued      <= '0;
        r_collected   <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_issue_fire)   r_issued    <= r_issued + CNT_W'(1);
        if (w_collect_fire) r_collected <= r_collected + CNT_W'(1);
        if (w_issue_fire && !w_collect_fire)
          r_outstanding <= r_outstanding + OUT_W'(1);
        else if (!w_issue_fire && w_collect_fire)
          r_outstanding <= r_outstanding - OUT_W'(1);
      end
      // Flushed products are dropped; a pending result still drains.
      if (w_collect_fire && !w_in_flush) begin
        r_res_valid <= 1'b1;
        r_res_data  <= i_mul_out_prod;
        r_res_last  <= (r_collected == (r_len - CNT_W'(1)));
      end else if (w_res_fire) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef FP16_VMUL_ABORT_EN
  // Abort status, captured on every entry into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_aborted <= 1'b0;
    else if ((w_state_nxt == S_DONE) && (r_state != S_DONE))
      r_aborted <= (r_state == S_FLUSH);
  end
`endif

endmodule
